// File: rtl/wasm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wasm_pkg
//  Description : Shared types and constants for the WebAssembly loader front
//                end: walker states, error codes, preamble bytes, section ids.
//  Revision    : 1.0  initial release
// ============================================================================
package wasm_pkg;

    // Walker state machine encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SEC_ID   = 3'd2,
        ST_SEC_SIZE = 3'd3,
        ST_EMIT     = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERROR    = 3'd6
    } wasm_state_e;

    // Error codes reported on err_code.
    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_BAD_MAGIC    = 3'd1;
    localparam logic [2:0] ERR_BAD_VERSION  = 3'd2;
    localparam logic [2:0] ERR_LEB_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_PAST_END     = 3'd4;
    localparam logic [2:0] ERR_TRUNCATED    = 3'd5;
    localparam logic [2:0] ERR_BAD_SEC_ID   = 3'd6;

    // Preamble, stored most-significant byte first = file order.
    localparam logic [31:0] WASM_MAGIC   = 32'h0061736d;
    localparam logic [31:0] WASM_VERSION = 32'h01000000;
    localparam int          PREAMBLE_LEN = 8;

    // Standard section ids.
    localparam logic [7:0] SEC_CUSTOM     = 8'd0;
    localparam logic [7:0] SEC_TYPE       = 8'd1;
    localparam logic [7:0] SEC_IMPORT     = 8'd2;
    localparam logic [7:0] SEC_FUNCTION   = 8'd3;
    localparam logic [7:0] SEC_TABLE      = 8'd4;
    localparam logic [7:0] SEC_MEMORY     = 8'd5;
    localparam logic [7:0] SEC_GLOBAL     = 8'd6;
    localparam logic [7:0] SEC_EXPORT     = 8'd7;
    localparam logic [7:0] SEC_START      = 8'd8;
    localparam logic [7:0] SEC_ELEMENT    = 8'd9;
    localparam logic [7:0] SEC_CODE       = 8'd10;
    localparam logic [7:0] SEC_DATA       = 8'd11;
    localparam logic [7:0] SEC_DATA_COUNT = 8'd12;

    // Expected preamble byte at file offset idx (0..7).
    function automatic logic [7:0] preamble_byte(input logic [2:0] idx);
        logic [63:0] seq;
        seq = {WASM_MAGIC, WASM_VERSION};
        seq = seq << {idx, 3'b000};
        return seq[63:56];
    endfunction

endpackage
`default_nettype wire

// File: rtl/wasm_leb128_u32.sv
`default_nettype none
// ============================================================================
//  Module      : wasm_leb128_u32
//  Description : Byte-serial unsigned LEB128 (u32) decoder. The value, done
//                and overflow outputs already include the byte on i_byte
//                while i_strobe is high, so the caller can act in that cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module wasm_leb128_u32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_strobe,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_value,
    output logic        o_done,
    output logic        o_overflow
);

    logic [31:0] r_acc;
    logic [2:0]  r_cnt;
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic        w_last;

    assign w_shamt   = 5'(r_cnt) * 5'd7;
    assign w_shifted = {25'd0, i_byte[6:0]} << w_shamt;
    assign w_last    = (r_cnt == 3'd4);

    // The fifth byte may carry only 4 payload bits and must terminate.
    assign o_overflow = i_strobe && w_last && (i_byte[7] || (|i_byte[6:4]));
    assign o_done     = i_strobe && !i_byte[7] && !o_overflow;
    assign o_value    = r_acc | (i_strobe ? w_shifted : 32'd0);

    // Accumulator and byte counter; count saturates at the fifth byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_strobe) begin
            r_acc <= o_value;
            if (!w_last) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wasm_section_walker.sv
`default_nettype none
// ============================================================================
//  Module      : wasm_section_walker
//  Description : Validates the wasm preamble and walks the section headers,
//                emitting one (id, size, offset) descriptor per section.
//                Reads are pipelined one byte per cycle: the next byte is
//                requested in the same cycle the previous one is consumed,
//                but only when it is certain to be consumed.
//  Revision    : 1.0  initial release
// ============================================================================
module wasm_section_walker
    import wasm_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int MAX_SEC_ID = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   module_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              sec_valid,
    input  logic              sec_ready,
    output logic [7:0]        sec_id,
    output logic [31:0]       sec_size,
    output logic [ADDR_W-1:0] sec_offset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code
);

    wasm_state_e       r_state, w_state_nx;
    logic [ADDR_W:0]   r_addr,  w_addr_nx;   // next byte address to request
    logic [ADDR_W:0]   r_len,   w_len_nx;
    logic              r_pend;               // mem_rdata holds the byte at r_addr-1
    logic [2:0]        r_err,   w_err_nx;
    logic [7:0]        r_id,    w_id_nx;
    logic [31:0]       r_size,  w_size_nx;
    logic [ADDR_W-1:0] r_offset, w_off_nx;

    logic              w_issue;
    logic              w_leb_clear;
    logic              w_leb_strobe;
    logic [31:0]       w_leb_value;
    logic              w_leb_done;
    logic              w_leb_ovf;
    logic [2:0]        w_pre_idx;
    logic [32:0]       w_next_hdr;
    logic [32:0]       w_len33;

    assign w_pre_idx  = r_addr[2:0] - 3'd1;
    assign w_len33    = {{(32-ADDR_W){1'b0}}, r_len};
    assign w_next_hdr = {{(32-ADDR_W){1'b0}}, r_addr} + {1'b0, w_leb_value};

    wasm_leb128_u32 u_leb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_leb_clear),
        .i_strobe   (w_leb_strobe),
        .i_byte     (mem_rdata),
        .o_value    (w_leb_value),
        .o_done     (w_leb_done),
        .o_overflow (w_leb_ovf)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_pend   <= 1'b0;
            r_err    <= ERR_NONE;
            r_id     <= '0;
            r_size   <= '0;
            r_offset <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_addr   <= w_addr_nx;
            r_len    <= w_len_nx;
            r_pend   <= w_issue;
            r_err    <= w_err_nx;
            r_id     <= w_id_nx;
            r_size   <= w_size_nx;
            r_offset <= w_off_nx;
        end
    end

    // Next-state, read issue and field capture decisions.
    always_comb begin
        w_state_nx   = r_state;
        w_addr_nx    = r_addr;
        w_len_nx     = r_len;
        w_err_nx     = r_err;
        w_id_nx      = r_id;
        w_size_nx    = r_size;
        w_off_nx     = r_offset;
        w_issue      = 1'b0;
        w_leb_clear  = 1'b0;
        w_leb_strobe = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_len_nx  = module_len;
                    w_err_nx  = ERR_NONE;
                    w_addr_nx = '0;
                    if (module_len < (ADDR_W+1)'(PREAMBLE_LEN)) begin
                        w_state_nx = ST_ERROR;
                        w_err_nx   = ERR_TRUNCATED;
                    end else begin
                        w_state_nx = ST_PREAMBLE;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!r_pend) begin
                    w_issue = 1'b1;                       // byte 0
                end else if (mem_rdata != preamble_byte(w_pre_idx)) begin
                    w_state_nx = ST_ERROR;
                    w_err_nx   = w_pre_idx[2] ? ERR_BAD_VERSION : ERR_BAD_MAGIC;
                end else if (w_pre_idx == 3'd7) begin
                    if (r_addr == r_len) begin
                        w_state_nx = ST_DONE;             // no sections
                    end else begin
                        w_issue    = 1'b1;                // first id byte
                        w_state_nx = ST_SEC_ID;
                    end
                end else begin
                    w_issue = 1'b1;
                end
            end
            ST_SEC_ID: begin
                if (!r_pend) begin
                    // Entered from EMIT: the header may end exactly at the tail.
                    if (r_addr == r_len) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_issue = 1'b1;
                    end
                end else if (mem_rdata > 8'(MAX_SEC_ID)) begin
                    w_state_nx = ST_ERROR;
                    w_err_nx   = ERR_BAD_SEC_ID;
                end else if (r_addr == r_len) begin
                    w_state_nx = ST_ERROR;
                    w_err_nx   = ERR_TRUNCATED;
                end else begin
                    w_id_nx     = mem_rdata;
                    w_leb_clear = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nx  = ST_SEC_SIZE;
                end
            end
            ST_SEC_SIZE: begin
                w_leb_strobe = r_pend;
                if (r_pend) begin
                    if (w_leb_ovf) begin
                        w_state_nx = ST_ERROR;
                        w_err_nx   = ERR_LEB_OVERFLOW;
                    end else if (w_leb_done) begin
                        if (w_next_hdr > w_len33) begin
                            w_state_nx = ST_ERROR;
                            w_err_nx   = ERR_PAST_END;
                        end else begin
                            w_size_nx  = w_leb_value;
                            w_off_nx   = r_addr[ADDR_W-1:0];
                            w_addr_nx  = w_next_hdr[ADDR_W:0];
                            w_state_nx = ST_EMIT;
                        end
                    end else if (r_addr == r_len) begin
                        w_state_nx = ST_ERROR;
                        w_err_nx   = ERR_TRUNCATED;
                    end else begin
                        w_issue = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (sec_ready) begin
                    w_state_nx = ST_SEC_ID;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_issue) begin
            w_addr_nx = r_addr + 1'b1;
        end
    end

    assign mem_rd_en  = w_issue;
    assign mem_addr   = r_addr[ADDR_W-1:0];
    assign sec_valid  = (r_state == ST_EMIT);
    assign sec_id     = r_id;
    assign sec_size   = r_size;
    assign sec_offset = r_offset;
    assign busy       = (r_state == ST_PREAMBLE) || (r_state == ST_SEC_ID) ||
                        (r_state == ST_SEC_SIZE) || (r_state == ST_EMIT);
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERROR);
    assign err_code   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wasm_section_walker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wasm_section_walker
//  Description : Directed self-checking bench for wasm_section_walker.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wasm_section_walker;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   module_len = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic              sec_valid;
    logic              sec_ready = 1'b0;
    logic [7:0]        sec_id;
    logic [31:0]       sec_size;
    logic [ADDR_W-1:0] sec_offset;
    logic              busy;
    logic              done;
    logic              error;
    logic [2:0]        err_code;

    logic [7:0] mem [0:4095];
    int rd_cnt  = 0;
    int vld_cnt = 0;
    int checks   = 0;
    int failures = 0;

    wasm_section_walker #(.ADDR_W(ADDR_W), .MAX_SEC_ID(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .module_len (module_len),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .sec_valid  (sec_valid),
        .sec_ready  (sec_ready),
        .sec_id     (sec_id),
        .sec_size   (sec_size),
        .sec_offset (sec_offset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory with one-cycle read latency, plus activity counters.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            rd_cnt    <= rd_cnt + 1;
        end
        if (sec_valid) begin
            vld_cnt <= vld_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_preamble();
        logic [7:0] pre [8];
        pre = '{8'h00, 8'h61, 8'h73, 8'h6d, 8'h01, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++)  mem[i] = pre[i];
    endtask

    task automatic load_two();
        load_preamble();
        mem[8]  = 8'h01; mem[9]  = 8'h05;
        for (int i = 10; i < 15; i++) mem[i] = 8'hAA;
        mem[15] = 8'h03; mem[16] = 8'h02;
        mem[17] = 8'hBB; mem[18] = 8'hBB;
    endtask

    // Called right after a falling edge; returns at the falling edge of cycle T+1.
    task automatic start_walk(input logic [ADDR_W:0] len);
        module_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // which=0: wait for sec_valid; which=1: wait for done or error.
    task automatic wait_ev(input int which, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if ((which == 0) ? sec_valid : (done || error)) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        ok = (which == 0) ? sec_valid : (done || error);
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_ctl"}, {mem_rd_en, mem_addr, sec_valid, busy, done, error, err_code}, 64'd0);
        check({tag, "_desc"}, {sec_id, sec_size, sec_offset}, 64'd0);
    endtask

    task automatic walk_two(input string p);
        bit ok;
        load_two();
        start_walk(13'd19);
        wait_ev(0, 40, ok);
        check({p, "_v1_seen"}, 64'(ok), 64'd1);
        check({p, "_desc1"}, {sec_id, sec_size, sec_offset}, {8'd1, 32'd5, 12'd10});
        for (int i = 0; i < 4; i++) begin
            if (i == 1) start = 1'b1;       // must be ignored while busy
            @(negedge clk);
            start = 1'b0;
            check({p, "_hold"}, {sec_valid, sec_id, sec_size, sec_offset},
                  {1'b1, 8'd1, 32'd5, 12'd10});
        end
        sec_ready = 1'b1;
        @(negedge clk);
        sec_ready = 1'b0;
        check({p, "_v1_drop"}, 64'(sec_valid), 64'd0);
        wait_ev(0, 40, ok);
        check({p, "_v2_seen"}, 64'(ok), 64'd1);
        check({p, "_desc2"}, {sec_id, sec_size, sec_offset}, {8'd3, 32'd2, 12'd17});
        sec_ready = 1'b1;
        @(negedge clk);
        sec_ready = 1'b0;
        wait_ev(1, 40, ok);
        check({p, "_end_seen"}, 64'(ok), 64'd1);
        check({p, "_end"}, {done, error, err_code, busy}, {1'b1, 1'b0, 3'd0, 1'b0});
    endtask

    task automatic run_err(input string tag, input logic [ADDR_W:0] len, input logic [2:0] code);
        bit ok;
        int v0;
        v0 = vld_cnt;
        start_walk(len);
        wait_ev(1, 60, ok);
        check({tag, "_seen"}, 64'(ok), 64'd1);
        check({tag, "_flags"}, {done, error, busy, err_code}, {1'b0, 1'b1, 1'b0, code});
        check({tag, "_novalid"}, 64'(vld_cnt - v0), 64'd0);
    endtask

    initial begin
        int rd0;
        int v0;
        bit ok;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Preamble only: done exactly at T+10
        load_preamble();
        rd0 = rd_cnt;
        v0  = vld_cnt;
        start_walk(13'd8);
        check("pre_first_read", {mem_rd_en, mem_addr, busy}, {1'b1, 12'd0, 1'b1});
        repeat (8) @(negedge clk);
        check("pre_done_t9", 64'(done), 64'd0);
        @(negedge clk);
        check("pre_done_t10", {done, error, err_code, busy}, {1'b1, 1'b0, 3'd0, 1'b0});
        check("pre_reads", 64'(rd_cnt - rd0), 64'd8);
        check("pre_novalid", 64'(vld_cnt - v0), 64'd0);

        // Two sections with back-pressure
        walk_two("two");

        // Bad magic at byte 2: exactly three reads, none afterwards
        load_preamble();
        mem[2] = 8'h72;
        rd0 = rd_cnt;
        run_err("magic", 13'd19, 3'd1);
        repeat (3) @(negedge clk);
        check("magic_reads", 64'(rd_cnt - rd0), 64'd3);

        // Bad version at byte 4
        load_preamble();
        mem[4] = 8'h02;
        run_err("version", 13'd19, 3'd2);

        // Length below preamble: error in T+1 with no read
        load_preamble();
        rd0 = rd_cnt;
        start_walk(13'd5);
        check("short_len", {error, err_code, busy}, {1'b1, 3'd5, 1'b0});
        @(negedge clk);
        check("short_reads", 64'(rd_cnt - rd0), 64'd0);

        // LEB128 overflow on the fifth size byte
        load_preamble();
        mem[8] = 8'h01;
        mem[9] = 8'h80; mem[10] = 8'h80; mem[11] = 8'h80; mem[12] = 8'h80; mem[13] = 8'h10;
        run_err("leb_ovf", 13'd20, 3'd3);

        // Section of 128 bytes past a 20-byte module
        load_preamble();
        mem[8] = 8'h01; mem[9] = 8'h80; mem[10] = 8'h01;
        run_err("past_end", 13'd20, 3'd4);

        // Section id above the legal range
        load_preamble();
        mem[8] = 8'h0e;
        run_err("bad_id", 13'd20, 3'd6);

        // Header cut after a continuation size byte
        load_preamble();
        mem[8] = 8'h01; mem[9] = 8'h85;
        run_err("trunc", 13'd10, 3'd5);

        // Zero-size section ending exactly at module_len
        load_preamble();
        mem[8] = 8'h00; mem[9] = 8'h00;
        start_walk(13'd10);
        wait_ev(0, 40, ok);
        check("zero_seen", 64'(ok), 64'd1);
        check("zero_desc", {sec_id, sec_size, sec_offset}, {8'd0, 32'd0, 12'd10});
        sec_ready = 1'b1;
        @(negedge clk);
        sec_ready = 1'b0;
        wait_ev(1, 40, ok);
        check("zero_end", {ok, done, error, err_code}, {1'b1, 1'b1, 1'b0, 3'd0});

        // Asynchronous reset while decoding the first size byte, then re-walk
        load_two();
        start_walk(13'd19);
        repeat (10) @(negedge clk);          // cycle T+11: size byte in flight
        check("rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        outputs_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        walk_two("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound in case a wait is never satisfied.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/wasm_section_walker.md
# wasm_section_walker

Front-end loader stage that runs directly after reset, before execution starts. It reads the WebAssembly binary byte-by-byte from the instruction byte memory and validates the 8-byte preamble (magic `00 61 73 6d`, version `01 00 00 00`). It then walks the section headers (id byte plus LEB128 u32 size) and hands one descriptor per section downstream over a valid/ready handshake. The core's decoders use these descriptors to locate the type, function, export and code sections without re-scanning the binary.

## Interface
Parameters:
- `ADDR_W`, 12: byte-address width of the instruction memory (4096 bytes).
- `MAX_SEC_ID`, 12: highest legal section id; any larger id is an error.

Ports:
- `clk` in 1: sole clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a walk. Only honoured in IDLE, DONE or ERROR.
- `module_len` in ADDR_W+1: binary length in bytes; sampled when `start` is accepted.
- `mem_rd_en` out 1: byte read request.
- `mem_addr` out ADDR_W: byte address.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_rd_en`.
- `sec_valid` out 1: a section descriptor is presented.
- `sec_ready` in 1: the consumer accepts the descriptor.
- `sec_id` out 8: section id.
- `sec_size` out 32: payload size in bytes.
- `sec_offset` out ADDR_W: address of the first payload byte.
- `busy` out 1: high from `start` acceptance until DONE or ERROR.
- `done` out 1: walk finished cleanly; held until the next `start`.
- `error` out 1: walk aborted; held until the next `start`.
- `err_code` out 3: 0 none, 1 bad magic, 2 bad version, 3 LEB128 overflow, 4 section past end, 5 truncated, 6 bad section id.

## Operation
- States: IDLE → PREAMBLE → SEC_ID → SEC_SIZE → EMIT → (SEC_ID | DONE); any check failure goes to ERROR.
- Reset: every output is 0; state is IDLE; internal address is 0.
- PREAMBLE:
  - Reads bytes 0..7 and compares each against the constant as it arrives.
  - The first mismatch at bytes 0-3 gives code 1; at bytes 4-7, code 2.
  - `module_len` < 8 gives code 5 without issuing any read.
- SEC_ID:
  - If the current address == `module_len`, go to DONE. Zero sections is legal.
  - Otherwise read the id byte. An id > MAX_SEC_ID gives code 6.
- SEC_SIZE:
  - Unsigned LEB128 accumulation: `acc |= (b & 7f) << 7*k`.
  - Error code 3 if a 5th byte has bit 7 set, or if the 5th byte has any of bits [6:4] set.
  - Reaching `module_len` before the terminating byte gives code 5.
- EMIT:
  - Present id, size and offset (the address after the last size byte).
  - The next header address is offset+size, computed at 33 bits. If it exceeds `module_len`, the result is code 4, reported instead of emitting.
  - A size of 0 is legal; the next header starts at offset.
- `start` while `busy` is ignored.
- Section ordering and duplicate sections are not checked here.

## Timing
- Let `start` be accepted in cycle T. The read of byte 0 is issued in T+1, and byte k is issued in T+1+k.
- Byte k is consumed in T+2+k. Reads are pipelined at one byte per cycle.
- `mem_rd_en` is only issued for bytes that will be consumed; no read is outstanding in EMIT, DONE or ERROR.
- `sec_valid` rises in the cycle after the last size byte is consumed.
- Descriptor fields are stable while `sec_valid && !sec_ready`.
- On the handshake cycle, the next id read is issued in the following cycle.
- `done` and `error` assert in the cycle after the deciding byte (or length check), and `busy` falls in the same cycle.
- Asserting `rst_n` low mid-walk clears everything asynchronously. A descriptor pending in EMIT is dropped.

## Structure
- Shared `wasm_pkg` holds:
  - The state enum.
  - The `err_code` constants.
  - `WASM_MAGIC` (32'h0061736d) and `WASM_VERSION` (32'h01000000) as byte sequences.
  - The section-id constants 0..12.
- Sub-module `wasm_leb128_u32`:
  - Byte-serial unsigned decoder with inputs clear and byte strobe.
  - Outputs value, done and overflow.
  - The core's immediate decoder will reuse it.

## Test plan
- Preamble only: `module_len`=8, correct bytes → `done`=1 at T+10, no `sec_valid`, `err_code`=0.
- Two sections. Bytes 8-18 are `01 05 xx xx xx xx xx 03 02 xx xx` and `module_len`=19:
  - Descriptor (1,5,10) is presented.
  - Then descriptor (3,2,17) is presented.
  - Then `done`.
  - Holding `sec_ready` low for 4 cycles keeps the fields stable.
- Byte 2 = `72` → `error`, code 1, after byte 2 is consumed, with no further reads. Byte 4 = `02` → code 2.
- Size `80 80 80 80 10` → code 3. Size `80 01` (128) with `module_len`=20 → code 4.
- Id byte `0e` → code 6. `module_len`=10 with the header cut after `01 85` → code 5.
- Pulse `rst_n` low during SEC_SIZE → all outputs 0 at once; a new `start` walks the two-section image correctly.
